// File: rtl/symm_mul_n_pkg.sv
// Shared definitions for the symmetric Gram-matrix multiplier (G = W * W^T).
// Holds the default Q-format parameters, the FSM state encoding and the
// saturation-limit helpers used by the MAC datapath.
package symm_mul_n_pkg;

  localparam int unsigned DefN    = 4;
  localparam int unsigned DefDw   = 26;
  localparam int unsigned DefFrac = 13;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMac  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Largest positive value of a dw-bit signed element.
  function automatic longint sat_max(input int unsigned dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  // Most negative value of a dw-bit signed element.
  function automatic longint sat_min(input int unsigned dw);
    return -(64'sd1 <<< (dw - 1));
  endfunction

endpackage

// File: rtl/symm_mul_n_if.sv
// Request/result bundle of symm_mul_n.
//   start  : request to compute G = W*W^T (honoured only when idle)
//   w_flat : signed row-major W, element [i][k] at bits (i*N+k)*DW
//   o_flat : registered copy of the last captured W
//   g_flat : signed row-major result G
//   busy   : high while the MAC sequence runs
//   done   : one-cycle pulse when G is complete
//   ovf    : sticky saturation flag for the current or last run
interface symm_mul_n_if
  import symm_mul_n_pkg::*;
#(
  parameter int unsigned N  = DefN,
  parameter int unsigned DW = DefDw
);
  logic                  start;
  logic [N*N*DW-1:0]     w_flat;
  logic [N*N*DW-1:0]     o_flat;
  logic [N*N*DW-1:0]     g_flat;
  logic                  busy;
  logic                  done;
  logic                  ovf;

  modport master (
    output start, w_flat,
    input  o_flat, g_flat, busy, done, ovf
  );

  modport slave (
    input  start, w_flat,
    output o_flat, g_flat, busy, done, ovf
  );
endinterface

// File: rtl/symm_mac.sv
// Signed multiply-accumulate lane for one G entry.
//   clk_muln, rst_muln : clock, synchronous active-high reset
//   clear              : zero the accumulator (new run accepted)
//   en, last           : accumulate this cycle; last marks k = N-1
//   a, b               : W[i][k] and W[j][k]
//   result             : floor((acc + a*b) >> FRAC), saturated to DW bits
//   ovf_evt            : result was clamped on a final (last) cycle
module symm_mac
  import symm_mul_n_pkg::*;
#(
  parameter int unsigned N    = DefN,
  parameter int unsigned DW   = DefDw,
  parameter int unsigned FRAC = DefFrac
) (
  input  logic                 clk_muln,
  input  logic                 rst_muln,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 last,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] result,
  output logic                 ovf_evt
);
  // Wide enough for N full-scale products, so the sum never wraps.
  localparam int unsigned AccW = 2 * DW + $clog2(N);
  localparam logic signed [AccW-1:0] SatMax = AccW'(sat_max(DW));
  localparam logic signed [AccW-1:0] SatMin = AccW'(sat_min(DW));

  logic signed [2*DW-1:0] product;
  logic signed [AccW-1:0] acc_q, acc_d, sum, shifted;
  logic                   clamp_hi, clamp_lo;

  always_comb begin
    product  = a * b;
    sum      = acc_q + AccW'(product);
    shifted  = sum >>> FRAC;
    clamp_hi = shifted > SatMax;
    clamp_lo = shifted < SatMin;
    if (clamp_hi) begin
      result = SatMax[DW-1:0];
    end else if (clamp_lo) begin
      result = SatMin[DW-1:0];
    end else begin
      result = shifted[DW-1:0];
    end
    ovf_evt = en & last & (clamp_hi | clamp_lo);

    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = last ? '0 : sum;
    end
  end

  always_ff @(posedge clk_muln) begin
    if (rst_muln) acc_q <= '0;
    else          acc_q <= acc_d;
  end
endmodule

// File: rtl/symm_mul_n.sv
// Computes G = W * W^T for an NxN signed Q-format matrix, one MAC per cycle.
// Only the upper triangle is evaluated; each result is mirrored into g[j][i].
//   clk_muln : sole clock, rising edge
//   rst_muln : synchronous active-high reset, overrides any run in flight
//   bus      : slave side of symm_mul_n_if (start/W in, o/G/busy/done/ovf out)
module symm_mul_n
  import symm_mul_n_pkg::*;
#(
  parameter int unsigned N    = DefN,
  parameter int unsigned DW   = DefDw,
  parameter int unsigned FRAC = DefFrac
) (
  input  logic        clk_muln,
  input  logic        rst_muln,
  symm_mul_n_if.slave bus
);
  localparam int unsigned IdxW  = $clog2(N);
  localparam int unsigned FlatW = N * N * DW;
  localparam logic [IdxW-1:0] Last = IdxW'(N - 1);

  state_e                state_q, state_d;
  logic [FlatW-1:0]      w_q, o_q, g_q;
  logic                  ovf_q;
  logic [IdxW-1:0]       i_q, j_q, k_q;
  logic                  accept, mac_en, k_last, pair_last;
  logic signed [DW-1:0]  op_a, op_b, mac_result;
  logic                  ovf_evt;

  assign k_last    = (k_q == Last);
  assign pair_last = (i_q == Last) && (j_q == Last);

  // FSM state register
  always_ff @(posedge clk_muln) begin
    if (rst_muln) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StMac;
      StMac:   if (k_last && pair_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    accept   = (state_q == StIdle) && bus.start;
    mac_en   = (state_q == StMac);
    bus.busy = mac_en;
    bus.done = (state_q == StDone);
  end

  always_comb begin
    op_a = w_q[(32'(i_q) * N + 32'(k_q)) * DW +: DW];
    op_b = w_q[(32'(j_q) * N + 32'(k_q)) * DW +: DW];
  end

  always_ff @(posedge clk_muln) begin
    if (rst_muln) begin
      w_q   <= '0;
      o_q   <= '0;
      g_q   <= '0;
      ovf_q <= 1'b0;
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
    end else if (accept) begin
      w_q   <= bus.w_flat;
      o_q   <= bus.w_flat;
      ovf_q <= 1'b0;
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
    end else if (mac_en) begin
      if (k_last) begin
        g_q[(32'(i_q) * N + 32'(j_q)) * DW +: DW] <= mac_result;
        g_q[(32'(j_q) * N + 32'(i_q)) * DW +: DW] <= mac_result;
        ovf_q <= ovf_q | ovf_evt;
        k_q   <= '0;
        // Upper-triangle walk: next row restarts on the diagonal.
        if (!pair_last) begin
          if (j_q == Last) begin
            i_q <= i_q + 1'b1;
            j_q <= i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
      end else begin
        k_q <= k_q + 1'b1;
      end
    end
  end

  assign bus.o_flat = o_q;
  assign bus.g_flat = g_q;
  assign bus.ovf    = ovf_q;

  symm_mac #(
    .N    (N),
    .DW   (DW),
    .FRAC (FRAC)
  ) u_mac (
    .clk_muln (clk_muln),
    .rst_muln (rst_muln),
    .clear    (accept),
    .en       (mac_en),
    .last     (k_last),
    .a        (op_a),
    .b        (op_b),
    .result   (mac_result),
    .ovf_evt  (ovf_evt)
  );
endmodule
